// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with per-register busy bits for issue scoreboarding.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            wen,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ok,
  output logic [AW:0]     nbusy
);
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic            wr, set_inc, clr_dec, byp1, byp2;
  logic [AW:0]     nbusy_n;
  assign wr = wen && wa != '0;
  assign iss_ok = iss_en && (iss_rd == '0 || !busy[iss_rd] || (wen && wa == iss_rd));
`ifdef REGFILE_BYPASS_EN
  assign byp1 = wr && wa == ra1;
  assign byp2 = wr && wa == ra2;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  always_comb begin
    rd1   = byp1 ? wd : (ra1 == '0 ? '0 : regs[ra1]);
    rd2   = byp2 ? wd : (ra2 == '0 ? '0 : regs[ra2]);
    busy1 = busy[ra1] && !byp1;
    busy2 = busy[ra2] && !byp2;
  end
  // An issue to an already-busy register adds nothing; a write whose clear is overridden by a same-index issue removes nothing.
  assign set_inc = iss_ok && iss_rd != '0 && !busy[iss_rd];
  assign clr_dec = wr && busy[wa] && !(iss_ok && iss_rd == wa);
  assign nbusy_n = nbusy + {{AW{1'b0}}, set_inc} - {{AW{1'b0}}, clr_dec};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy  <= '0;
      nbusy <= '0;
    end else begin
      if (wr) begin
        regs[wa] <= wd;
        busy[wa] <= 1'b0;
      end
      if (iss_ok && iss_rd != '0) busy[iss_rd] <= 1'b1;
      nbusy <= nbusy_n;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed checks of reads, writeback, issue scoreboarding and reset.
module tb_regfile_scoreboard;
  logic        clk, rst_n;
  logic [4:0]  ra1, ra2, wa, iss_rd;
  logic [31:0] rd1, rd2, wd;
  logic        busy1, busy2, wen, iss_en, iss_ok;
  logic [5:0]  nbusy;
  int checks = 0;
  int failures = 0;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .wa(wa), .wd(wd), .wen(wen),
    .iss_en(iss_en), .iss_rd(iss_rd), .iss_ok(iss_ok), .nbusy(nbusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ra1 = '0; ra2 = '0; wa = '0; wd = '0; wen = 1'b0; iss_en = 1'b0; iss_rd = '0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      chk("reset_rd1", rd1, 32'h0);
      chk("reset_busy1", {31'b0, busy1}, 32'h0);
      chk("reset_rd2", rd2, 32'h0);
      chk("reset_busy2", {31'b0, busy2}, 32'h0);
    end
    chk("reset_nbusy", {26'b0, nbusy}, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      wen = 1'b1; wa = 5'(i); wd = 32'h100 + i;
      tick();
    end
    wen = 1'b0; ra1 = 5'd2; ra2 = 5'd3;
    #1;
    chk("plain_write_rd1", rd1, 32'h102);
    chk("plain_write_rd2", rd2, 32'h103);
    chk("plain_write_nbusy", {26'b0, nbusy}, 32'h0);
    iss_en = 1'b1; iss_rd = 5'd5;
    #1;
    chk("issue5_ok", {31'b0, iss_ok}, 32'h1);
    tick();
    ra1 = 5'd5;
    #1;
    chk("issue5_nbusy", {26'b0, nbusy}, 32'h1);
    chk("issue5_busy1", {31'b0, busy1}, 32'h1);
    chk("reissue5_ok", {31'b0, iss_ok}, 32'h0);
    tick();
    chk("reissue5_nbusy", {26'b0, nbusy}, 32'h1);
    wen = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    #1;
    chk("wb_issue5_ok", {31'b0, iss_ok}, 32'h1);
    tick();
    wen = 1'b0; iss_en = 1'b0;
    #1;
    chk("wb_issue5_rd1", rd1, 32'hDEADBEEF);
    chk("wb_issue5_busy1", {31'b0, busy1}, 32'h1);
    chk("wb_issue5_nbusy", {26'b0, nbusy}, 32'h1);
    wen = 1'b1; wa = 5'd5; wd = 32'h55;
    tick();
    wen = 1'b0;
    #1;
    chk("clear5_busy1", {31'b0, busy1}, 32'h0);
    chk("clear5_rd1", rd1, 32'h55);
    chk("clear5_nbusy", {26'b0, nbusy}, 32'h0);
    wen = 1'b1; wa = 5'd7; wd = 32'h1234; ra1 = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("write7_same_cycle_rd1", rd1, 32'h1234);
`else
    chk("write7_same_cycle_rd1", rd1, 32'h0);
`endif
    tick();
    wen = 1'b0;
    #1;
    chk("write7_next_cycle_rd1", rd1, 32'h1234);
    iss_en = 1'b1; iss_rd = 5'd4;
    tick();
    wen = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; iss_rd = 5'd0;
    #1;
    chk("zero_issue_ok", {31'b0, iss_ok}, 32'h1);
    tick();
    wen = 1'b0; iss_en = 1'b0; ra1 = 5'd0; ra2 = 5'd4;
    #1;
    chk("zero_rd1", rd1, 32'h0);
    chk("zero_busy1", {31'b0, busy1}, 32'h0);
    chk("zero_busy2_reg4", {31'b0, busy2}, 32'h1);
    chk("zero_nbusy", {26'b0, nbusy}, 32'h1);
    wen = 1'b1; wa = 5'd4; wd = 32'h44; iss_en = 1'b1; iss_rd = 5'd6;
    #1;
    chk("diff_idx_ok", {31'b0, iss_ok}, 32'h1);
    tick();
    wen = 1'b0; iss_en = 1'b0; ra1 = 5'd6;
    #1;
    chk("diff_idx_busy4", {31'b0, busy2}, 32'h0);
    chk("diff_idx_rd4", rd2, 32'h44);
    chk("diff_idx_busy6", {31'b0, busy1}, 32'h1);
    chk("diff_idx_nbusy", {26'b0, nbusy}, 32'h1);
    wen = 1'b1; wa = 5'd4; iss_en = 1'b1; iss_rd = 5'd6;
    #1;
    chk("stall_busy6_ok", {31'b0, iss_ok}, 32'h0);
    iss_en = 1'b0; wa = 5'd6; wd = 32'h66;
    tick();
    wen = 1'b0;
    #1;
    chk("clear6_nbusy", {26'b0, nbusy}, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      iss_en = 1'b1; iss_rd = 5'(i);
      tick();
    end
    iss_en = 1'b0;
    #1;
    chk("issue123_nbusy", {26'b0, nbusy}, 32'h3);
    rst_n = 1'b0; wen = 1'b1; wa = 5'd2; wd = 32'hABC; iss_en = 1'b1; iss_rd = 5'd9;
    tick();
    rst_n = 1'b1; wen = 1'b0; iss_en = 1'b0; ra1 = 5'd2; ra2 = 5'd7;
    #1;
    chk("rst_mid_nbusy", {26'b0, nbusy}, 32'h0);
    chk("rst_mid_busy2", {31'b0, busy1}, 32'h0);
    chk("rst_mid_rd2", rd1, 32'h0);
    chk("rst_mid_rd7", rd2, 32'h0);
    ra1 = 5'd1; ra2 = 5'd9;
    #1;
    chk("rst_mid_busy1", {31'b0, busy1}, 32'h0);
    chk("rst_mid_busy9", {31'b0, busy2}, 32'h0);
    iss_en = 1'b1; iss_rd = 5'd2;
    #1;
    chk("post_rst_issue2_ok", {31'b0, iss_ok}, 32'h1);
    tick();
    iss_en = 1'b0;
    #1;
    chk("post_rst_issue2_nbusy", {26'b0, nbusy}, 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
